// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if: byte write port of the packet UART transmitter (valid/ready with last flag).
interface uart_packet_tx_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: FIFO-buffered 8N1 UART transmitter that idles GAP_BITS bit-times after each packet.
// Define UART_PKT_PARITY_EN to append an even parity bit after the data bits.
module uart_packet_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_BITS   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_packet_tx_if.slave             wr,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(GAP_BITS > 8 ? GAP_BITS : 8);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PKT_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic          push, pop, empty, bit_end;

    assign wr.wr_ready = count_q != (AW+1)'(FIFO_DEPTH);
    assign push        = wr.wr_valid && wr.wr_ready;
    assign empty       = count_q == '0;
    assign bit_end     = cnt_q == CW'(DIV - 1);
    assign txd         = txd_q;
    assign busy        = busy_q;
    assign fifo_level  = count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = !empty;
                state_d = empty ? IDLE : START;
            end
            START: begin
                state_d = bit_end ? DATA : START;
                bit_d   = bit_end ? '0 : bit_q;
            end
            DATA: if (bit_end) begin
                bit_d = bit_q + 1'b1;
`ifdef UART_PKT_PARITY_EN
                state_d = bit_q == BW'(7) ? PARITY : DATA;
            end
            PARITY: begin
                state_d = bit_end ? STOP : PARITY;
`else
                state_d = bit_q == BW'(7) ? STOP : DATA;
`endif
            end
            STOP: if (bit_end) begin
                // a non-last byte chains straight into the next start bit
                pop     = !last_q && !empty;
                state_d = last_q ? GAP : (empty ? IDLE : START);
                bit_d   = '0;
            end
            GAP: if (bit_end) begin
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == BW'(GAP_BITS - 1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        {last_d, data_d} = pop ? mem_q[rp_q] : {last_q, data_q};
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        txd_d   = state_q == START ? 1'b0 : state_q == DATA ? data_q[bit_q[2:0]] : 1'b1;
`ifdef UART_PKT_PARITY_EN
        txd_d   = state_q == PARITY ? ^data_q : txd_d;
`endif
        busy_d  = state_q != IDLE || !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            last_q  <= last_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {wr.wr_last, wr.wr_data};
    end
endmodule
